// File: rtl/calc_pkg.sv
// Shared types for the calculator sequencer.
//   op_t    : operator encoding, matches the op_sel input
//   state_t : sequencer states
//   SRC_*   : display_src encodings for the display driver
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_ENTRY_A = 2'd0,
    ST_ENTRY_B = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  localparam logic [1:0] SRC_A      = 2'd0;
  localparam logic [1:0] SRC_B      = 2'd1;
  localparam logic [1:0] SRC_RESULT = 2'd2;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle,
// MSB first.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   start           : load operands (first iteration happens on this edge)
//   abort           : synchronous cancel of a running operation
//   is_div          : 1 = divide op_a / op_b, 0 = multiply op_a * op_b
//   op_a, op_b      : unsigned operands, sampled on start
//   done            : one-cycle pulse once WIDTH iterations are complete
//   product         : 2*WIDTH-bit product (valid with done)
//   quotient        : WIDTH-bit quotient (valid with done)
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // acc holds the running product (mul) or the partial remainder (div).
  // sh holds the multiplier (mul) or dividend shifting out / quotient
  // shifting in (div).
  logic [2*WIDTH-1:0] acc_q, acc_d, src_acc, step_acc;
  logic [WIDTH-1:0]   sh_q, sh_d, src_sh, step_sh;
  logic [WIDTH-1:0]   opnd_q, opnd_d, src_opnd;
  logic               div_q, div_d, src_div;
  logic               run_q, run_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_shift;

  // The start edge already performs iteration 1, so a result is ready
  // after WIDTH-1 further edges and the caller sees exactly WIDTH busy
  // cycles.
  always_comb begin
    src_acc   = start ? '0 : acc_q;
    src_sh    = start ? (is_div ? op_a : op_b) : sh_q;
    src_opnd  = start ? (is_div ? op_b : op_a) : opnd_q;
    src_div   = start ? is_div : div_q;
    rem_shift = {src_acc[WIDTH-1:0], src_sh[WIDTH-1]};
    if (src_div) begin
      if (rem_shift >= {1'b0, src_opnd}) begin
        // True difference is below the divisor, so WIDTH bits suffice.
        step_acc = {{WIDTH{1'b0}}, rem_shift[WIDTH-1:0] - src_opnd};
        step_sh  = {src_sh[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = {{WIDTH{1'b0}}, rem_shift[WIDTH-1:0]};
        step_sh  = {src_sh[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc = {src_acc[2*WIDTH-2:0], 1'b0}
               + (src_sh[WIDTH-1] ? {{WIDTH{1'b0}}, src_opnd} : '0);
      step_sh  = {src_sh[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    run_d  = run_q;
    cnt_d  = cnt_q;
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      acc_d  = step_acc;
      sh_d   = step_sh;
      opnd_d = src_opnd;
      div_d  = src_div;
      run_d  = 1'b1;
      cnt_d  = CNT_W'(1);
    end else if (run_q) begin
      if (cnt_q == CNT_W'(WIDTH)) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        acc_d = step_acc;
        sh_d  = step_sh;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      run_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      run_q  <= run_d;
      cnt_q  <= cnt_d;
    end
  end

  assign done     = run_q && (cnt_q == CNT_W'(WIDTH));
  assign product  = acc_q;
  assign quotient = sh_q;

endmodule

// File: rtl/calc_sequencer.sv
// Operand/operator sequencer and arithmetic core for the calculator.
// Captures A, B and the operator, computes (add/sub in one cycle, mul/div
// iteratively), saturates to MAX_VALUE and shows the result; ent in RESULT
// chains the result into the next A.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   ent, clr       : single-cycle debounced pulses (clr has priority)
//   operand_in     : live unsigned slider value
//   op_sel         : 0 add, 1 sub, 2 mul, 3 div
//   display_value  : value for the display driver (magnitude)
//   display_src    : 0 A entry, 1 B entry / computing, 2 result
//   busy           : registered, high for every COMPUTE cycle
//   neg, overflow, div_err : result flags, valid in RESULT
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH     = 14,
  parameter int MAX_VALUE = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ent,
  input  logic             clr,
  input  logic [WIDTH-1:0] operand_in,
  input  logic [1:0]       op_sel,
  output logic [WIDTH-1:0] display_value,
  output logic [1:0]       display_src,
  output logic             busy,
  output logic             neg,
  output logic             overflow,
  output logic             div_err
);

  localparam logic [2*WIDTH-1:0] MAX_WIDE = (2*WIDTH)'(MAX_VALUE);

  function automatic logic [WIDTH-1:0] sat_mag(input logic [2*WIDTH-1:0] mag);
    return (mag > MAX_WIDE) ? WIDTH'(MAX_VALUE) : mag[WIDTH-1:0];
  endfunction

  function automatic logic sat_ovf(input logic [2*WIDTH-1:0] mag);
    return mag > MAX_WIDE;
  endfunction

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic               busy_q, busy_d, neg_q, neg_d;
  logic               ovf_q, ovf_d, derr_q, derr_d;

  logic               iu_start, iu_is_div, iu_done;
  logic [2*WIDTH-1:0] iu_product;
  logic [WIDTH-1:0]   iu_quotient;

  logic signed [WIDTH:0] diff_s;
  logic [WIDTH:0]        diff_mag;
  logic [2*WIDTH-1:0]    mag;
  logic                  finish, neg_v, derr_v;

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (iu_start),
    .abort    (clr),
    .is_div   (iu_is_div),
    .op_a     (a_q),
    .op_b     (operand_in),
    .done     (iu_done),
    .product  (iu_product),
    .quotient (iu_quotient)
  );

  // Signed difference of the zero-extended operands gives sign and magnitude.
  assign diff_s   = $signed({1'b0, a_q}) - $signed({1'b0, b_q});
  assign diff_mag = diff_s[WIDTH] ? $unsigned(-diff_s) : $unsigned(diff_s);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    derr_d    = derr_q;
    iu_start  = 1'b0;
    iu_is_div = (op_t'(op_sel) == OP_DIV);
    mag       = '0;
    finish    = 1'b0;
    neg_v     = 1'b0;
    derr_v    = 1'b0;

    unique case (state_q)
      ST_ENTRY_A: begin
        if (ent) begin
          a_d     = operand_in;
          state_d = ST_ENTRY_B;
        end
      end
      ST_ENTRY_B: begin
        if (ent) begin
          b_d     = operand_in;
          op_d    = op_t'(op_sel);
          state_d = ST_COMPUTE;
          // The iterator loads on this same edge, straight from operand_in.
          iu_start = (op_t'(op_sel) == OP_MUL)
                  || ((op_t'(op_sel) == OP_DIV) && (operand_in != '0));
        end
      end
      ST_COMPUTE: begin
        unique case (op_q)
          OP_ADD: begin
            mag    = (2*WIDTH)'(a_q) + (2*WIDTH)'(b_q);
            finish = 1'b1;
          end
          OP_SUB: begin
            mag    = (2*WIDTH)'(diff_mag);
            neg_v  = diff_s[WIDTH];
            finish = 1'b1;
          end
          OP_MUL: begin
            mag    = iu_product;
            finish = iu_done;
          end
          OP_DIV: begin
            if (b_q == '0) begin
              derr_v = 1'b1;
              finish = 1'b1;
            end else begin
              mag    = (2*WIDTH)'(iu_quotient);
              finish = iu_done;
            end
          end
          default: ;
        endcase
        if (finish) begin
          result_d = sat_mag(mag);
          ovf_d    = sat_ovf(mag);
          neg_d    = neg_v;
          derr_d   = derr_v;
          state_d  = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (ent) begin
          // A negative result cannot be an unsigned operand; chain zero.
          a_d     = neg_q ? '0 : result_q;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          derr_d  = 1'b0;
          state_d = ST_ENTRY_B;
        end
      end
      default: state_d = ST_ENTRY_A;
    endcase

    if (clr) begin
      state_d  = ST_ENTRY_A;
      op_d     = OP_ADD;
      a_d      = '0;
      b_d      = '0;
      result_d = '0;
      neg_d    = 1'b0;
      ovf_d    = 1'b0;
      derr_d   = 1'b0;
      iu_start = 1'b0;
    end

    busy_d = (state_d == ST_COMPUTE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_ENTRY_A;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      derr_q   <= derr_d;
    end
  end

  always_comb begin
    display_value = operand_in;
    display_src   = SRC_A;
    unique case (state_q)
      ST_ENTRY_A: begin
        display_value = operand_in;
        display_src   = SRC_A;
      end
      ST_ENTRY_B: begin
        display_value = operand_in;
        display_src   = SRC_B;
      end
      ST_COMPUTE: begin
        display_value = b_q;
        display_src   = SRC_B;
      end
      ST_RESULT: begin
        display_value = result_q;
        display_src   = SRC_RESULT;
      end
      default: ;
    endcase
  end

  assign busy     = busy_q;
  assign neg      = neg_q;
  assign overflow = ovf_q;
  assign div_err  = derr_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (WIDTH = 14, MAX_VALUE = 9999).
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, ent, clr;
  logic [13:0] operand_in;
  logic [1:0]  op_sel;
  logic [13:0] display_value;
  logic [1:0]  display_src;
  logic        busy, neg, overflow, div_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.WIDTH(14), .MAX_VALUE(9999)) dut (
    .clk           (clk),
    .reset         (reset),
    .ent           (ent),
    .clr           (clr),
    .operand_in    (operand_in),
    .op_sel        (op_sel),
    .display_value (display_value),
    .display_src   (display_src),
    .busy          (busy),
    .neg           (neg),
    .overflow      (overflow),
    .div_err       (div_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_ent();
    ent = 1'b1;
    tick();
    ent = 1'b0;
  endtask

  task automatic press_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // From ENTRY_A: enter A, then B/op; returns just after edge k.
  task automatic start_op(input int a, input int b, input logic [1:0] op);
    operand_in = 14'(a);
    press_ent();
    operand_in = 14'(b);
    op_sel = op;
    press_ent();
  endtask

  // cyc = edges after k until RESULT is visible; bcnt = busy samples seen.
  task automatic wait_result(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (display_src !== 2'd2 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ent = 1'b0; clr = 1'b0; operand_in = 14'd123; op_sel = 2'd0;
    #3;
    vectors++; if (display_value !== 14'd123) begin miscompares++; $display("FAIL reset_display: got %0d expected 123", display_value); end
    vectors++; if (display_src !== 2'd0) begin miscompares++; $display("FAIL reset_src: got %0d expected 0", display_src); end
    vectors++; if ({busy, neg, overflow, div_err} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", {busy, neg, overflow, div_err}); end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    int cyc, bcnt;
    start_op(25, 17, 2'd0);
    wait_result(cyc, bcnt);
    vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL add_latency: got %0d expected 1", cyc); end
    vectors++; if (display_value !== 14'd42) begin miscompares++; $display("FAIL add_value: got %0d expected 42", display_value); end
    vectors++; if (display_src !== 2'd2) begin miscompares++; $display("FAIL add_src: got %0d expected 2", display_src); end
    vectors++; if ({busy, neg, overflow, div_err} !== 4'b0000) begin miscompares++; $display("FAIL add_flags: got %b expected 0000", {busy, neg, overflow, div_err}); end
    press_clr();
  endtask

  task automatic test_sub_chain();
    int cyc, bcnt;
    start_op(12, 30, 2'd1);
    wait_result(cyc, bcnt);
    vectors++; if (display_value !== 14'd18) begin miscompares++; $display("FAIL sub_value: got %0d expected 18", display_value); end
    vectors++; if (neg !== 1'b1) begin miscompares++; $display("FAIL sub_neg: got %b expected 1", neg); end
    // Chaining a negative result makes A zero.
    operand_in = 14'd77;
    press_ent();
    vectors++; if (display_src !== 2'd1 || display_value !== 14'd77) begin miscompares++; $display("FAIL chain_entry_b: got src %0d val %0d expected src 1 val 77", display_src, display_value); end
    vectors++; if (neg !== 1'b0) begin miscompares++; $display("FAIL chain_neg_clear: got %b expected 0", neg); end
    operand_in = 14'd5; op_sel = 2'd0;
    press_ent();
    wait_result(cyc, bcnt);
    vectors++; if (display_value !== 14'd5) begin miscompares++; $display("FAIL chain_neg_zero_a: got %0d expected 5", display_value); end
    press_clr();
  endtask

  task automatic test_mul();
    int cyc, bcnt;
    start_op(123, 45, 2'd2);
    vectors++; if (display_src !== 2'd1 || display_value !== 14'd45) begin miscompares++; $display("FAIL mul_compute_display: got src %0d val %0d expected src 1 val 45", display_src, display_value); end
    wait_result(cyc, bcnt);
    vectors++; if (cyc !== 14) begin miscompares++; $display("FAIL mul_latency: got %0d expected 14", cyc); end
    vectors++; if (bcnt !== 14) begin miscompares++; $display("FAIL mul_busy_cycles: got %0d expected 14", bcnt); end
    vectors++; if (display_value !== 14'd5535) begin miscompares++; $display("FAIL mul_value: got %0d expected 5535", display_value); end
    vectors++; if (busy !== 1'b0 || overflow !== 1'b0) begin miscompares++; $display("FAIL mul_flags: got busy %b ovf %b expected 0 0", busy, overflow); end
    press_clr();
  endtask

  task automatic test_sat_chain();
    int cyc, bcnt;
    start_op(200, 100, 2'd2);
    wait_result(cyc, bcnt);
    vectors++; if (display_value !== 14'd9999) begin miscompares++; $display("FAIL sat_value: got %0d expected 9999", display_value); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL sat_ovf: got %b expected 1", overflow); end
    press_ent();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL chain_ovf_clear: got %b expected 0", overflow); end
    operand_in = 14'd2; op_sel = 2'd3;
    press_ent();
    wait_result(cyc, bcnt);
    vectors++; if (cyc !== 14) begin miscompares++; $display("FAIL div_latency: got %0d expected 14", cyc); end
    vectors++; if (display_value !== 14'd4999) begin miscompares++; $display("FAIL chain_div_value: got %0d expected 4999", display_value); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL chain_div_ovf: got %b expected 0", overflow); end
    press_clr();
  endtask

  task automatic test_div();
    int cyc, bcnt;
    start_op(100, 0, 2'd3);
    wait_result(cyc, bcnt);
    vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL div0_latency: got %0d expected 1", cyc); end
    vectors++; if (display_value !== 14'd0 || div_err !== 1'b1) begin miscompares++; $display("FAIL div0_result: got val %0d err %b expected 0 1", display_value, div_err); end
    press_clr();
    vectors++; if (div_err !== 1'b0) begin miscompares++; $display("FAIL clr_div_err: got %b expected 0", div_err); end
    start_op(100, 7, 2'd3);
    wait_result(cyc, bcnt);
    vectors++; if (display_value !== 14'd14 || div_err !== 1'b0) begin miscompares++; $display("FAIL div_value: got val %0d err %b expected 14 0", display_value, div_err); end
    press_clr();
  endtask

  task automatic test_abort();
    start_op(123, 45, 2'd2);
    repeat (4) tick();
    operand_in = 14'd321;
    press_clr();
    vectors++; if (display_src !== 2'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_state: got src %0d busy %b expected 0 0", display_src, busy); end
    repeat (15) tick();
    vectors++; if (display_src !== 2'd0 || display_value !== 14'd321) begin miscompares++; $display("FAIL abort_no_resume: got src %0d val %0d expected 0 321", display_src, display_value); end
    // ent and clr together in ENTRY_B: clr wins.
    operand_in = 14'd50;
    press_ent();
    ent = 1'b1; clr = 1'b1;
    tick();
    ent = 1'b0; clr = 1'b0;
    vectors++; if (display_src !== 2'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL ent_clr_priority: got src %0d busy %b expected 0 0", display_src, busy); end
  endtask

  task automatic test_reset_mid();
    start_op(100, 7, 2'd3);
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    vectors++; if (display_src !== 2'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL async_reset: got src %0d busy %b expected 0 0", display_src, busy); end
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    vectors++; if (display_src !== 2'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_no_resume: got src %0d busy %b expected 0 0", display_src, busy); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcnt;
    start_op(1, 2, 2'd0);
    wait_result(cyc, bcnt);
    vectors++; if (display_value !== 14'd3) begin miscompares++; $display("FAIL b2b_add: got %0d expected 3", display_value); end
    press_ent();
    operand_in = 14'd4; op_sel = 2'd2;
    press_ent();
    wait_result(cyc, bcnt);
    vectors++; if (display_value !== 14'd12) begin miscompares++; $display("FAIL b2b_chain_mul: got %0d expected 12", display_value); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_chain();
    test_mul();
    test_sat_chain();
    test_div();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Parametrised operand/operator sequencer and arithmetic core for the seven-segment calculator. It replaces the fixed two-operand add/sub datapath with several features:
- a state machine that captures operand A, operand B and the operator, then computes and shows the result;
- chained operations, where the result becomes the next A;
- iterative multiply and divide;
- saturation, sign and error flags.

It sits between the debounced input/slider logic and the display driver.

## Interface
- WIDTH, 14, operand/result width in bits.
- MAX_VALUE, 9999, largest displayable magnitude; results above it saturate.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ent  in  1  debounced enter, single-cycle pulse.
- clr  in  1  debounced clear, single-cycle pulse.
- operand_in  in  WIDTH  live value from the slider entry logic, unsigned.
- op_sel  in  2  operator: 0 add, 1 sub, 2 mul, 3 div.
- display_value  out  WIDTH  value for the display driver.
- display_src  out  2  0 operand A entry, 1 operand B entry, 2 result.
- busy  out  1  high while computing.
- neg  out  1  result is negative; display_value holds the magnitude.
- overflow  out  1  result saturated to MAX_VALUE.
- div_err  out  1  divide by zero occurred.

## Operation
- States: ENTRY_A, ENTRY_B, COMPUTE, RESULT.
- ENTRY_A: display_value = operand_in, display_src = 0. On ent, latch A = operand_in and go to ENTRY_B.
- ENTRY_B: display_value = operand_in, display_src = 1. On ent, latch B = operand_in, latch op = op_sel, go to COMPUTE.
- COMPUTE: display_value holds the last shown value, display_src = 1, busy = 1. ent is ignored.
  - add: A+B.
  - sub: |A−B|, with neg = (A<B).
  - mul: shift-add, one bit per cycle.
  - div: restoring divide, one quotient bit per cycle; the remainder is discarded.
- RESULT: display_value = result, display_src = 2, flags valid. On ent, A = result and go to ENTRY_B (chaining).
  - If neg = 1 when chaining, A = 0.
  - Flags clear when ENTRY_B is entered.
- Saturation: if the full-precision magnitude (2·WIDTH bits for mul) exceeds MAX_VALUE, result = MAX_VALUE and overflow = 1.
- Divide by zero (B = 0, op = div): result = 0, div_err = 1, no iteration.
- clr in any state: go to ENTRY_A and clear A, B, result and all flags, including an in-flight mul/div.
- ent and clr in the same cycle: clr wins.
- Reset values: state ENTRY_A; A, B, result = 0; busy, neg, overflow, div_err = 0; display_src = 0; display_value = operand_in (combinational pass-through in ENTRY_A).

## Timing
- Define edge k as the clock edge at which ent is sampled in ENTRY_B.
- COMPUTE begins at k+1.
- add/sub: a single COMPUTE cycle; RESULT and valid display_value from k+2.
- mul/div: WIDTH COMPUTE cycles; RESULT from k+1+WIDTH (k+15 at WIDTH = 14).
- Divide by zero: RESULT at k+2.
- busy is registered: high exactly for the cycles the state is COMPUTE.
- Flags change only on entry to RESULT, or on clear/reset.
- Reset asserted mid-COMPUTE: outputs take reset values immediately (asynchronous); the computation does not resume after release.

## Structure
- Package calc_pkg holds:
  - op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
  - state_t enum;
  - the display_src encodings.
- Sub-module calc_iter_unit:
  - WIDTH-parametrised shift-add multiplier / restoring divider;
  - start/done handshake, where done pulses for one cycle after WIDTH iterations;
  - outputs a 2·WIDTH-bit product or a WIDTH-bit quotient;
  - synchronous abort input driven by clr.
- Add/sub, saturation and flag logic live in calc_sequencer.

## Test plan
All scenarios use WIDTH = 14, MAX_VALUE = 9999.
- Reset, then A = 25, B = 17, op add → result 42 at k+2; flags 0; display_src = 2.
- A = 12, B = 30, op sub → display_value 18, neg = 1.
- A = 123, B = 45, op mul → busy high for 14 cycles, result 5535 at k+15.
- Saturation and chaining:
  - A = 200, B = 100, mul → 9999 with overflow = 1;
  - then ent, B = 2, div → 4999, overflow cleared.
- A = 100, B = 0, div → result 0, div_err = 1 at k+2. Then A = 100, B = 7, div → 14.
- Abort cases:
  - clr at cycle 5 of a mul → ENTRY_A next cycle, busy = 0, all registers 0;
  - ent and clr in the same cycle → clr wins;
  - reset pulsed mid-div → immediate reset values.
